// File: rtl/mux_tree_pipe_pkg.sv
// Shared constants and helpers for the pipelined N:1 mux tree.
package mux_tree_pkg;

    localparam logic MODE_EXT  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    // Number of 2:1 pairs (and outputs) produced by tree level k
    function automatic int unsigned pair_count(int unsigned num_ch, int unsigned level);
        return num_ch >> (level + 1);
    endfunction

    // Item offset of the data entering tree level k inside the flattened tree vector
    function automatic int unsigned tree_offset(int unsigned num_ch, int unsigned level);
        return (2 * num_ch) - (2 * (num_ch >> level));
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Producer/consumer bus of the pipelined mux tree (input beat side and output beat side).
interface mux_tree_pipe_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 1
);
    localparam int unsigned LEVELS = $clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [LEVELS-1:0]        in_sel;
    logic                     in_mode;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [LEVELS-1:0]        out_ch;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_sel, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_tree_pipe_stage.sv
// One registered level of the mux tree: 2:1 pair reduction plus valid/select registers.
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int unsigned LEVEL  = 0,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 1
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               i_valid,
    input  logic [(NUM_CH>>LEVEL)*DATA_W-1:0]                  i_data,
    input  logic [$clog2(NUM_CH)-1:0]                          i_sel,
    input  logic                                               i_ld_dn,
    output logic                                               o_valid,
    output logic [pair_count(NUM_CH, LEVEL)*DATA_W-1:0]        o_data,
    output logic [$clog2(NUM_CH)-1:0]                          o_sel
);
    localparam int unsigned LEVELS = $clog2(NUM_CH);
    localparam int unsigned PAIRS  = pair_count(NUM_CH, LEVEL);

    logic                      w_ld;
    logic [PAIRS*DATA_W-1:0]   w_red;
    logic                      r_valid;
    logic [PAIRS*DATA_W-1:0]   r_data;
    logic [LEVELS-1:0]         r_sel;

    // Empty stage always loads (bubble compression); full stage loads when downstream loads
    assign w_ld = !r_valid || i_ld_dn;

    // Reduce each input pair using this level's select bit
    always_comb begin
        w_red = '0;
        for (int unsigned j = 0; j < PAIRS; j++) begin
            w_red[j*DATA_W +: DATA_W] = i_sel[LEVEL] ? i_data[(2*j+1)*DATA_W +: DATA_W]
                                                     : i_data[(2*j)*DATA_W +: DATA_W];
        end
    end

    // Stage register: captures upstream beat (or bubble) on load, holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_ld) begin
            r_valid <= i_valid;
            r_data  <= w_red;
            r_sel   <= i_sel;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sel   = r_sel;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_CH:1 channel selector with valid/ready backpressure.
// Optional scan mode (internal channel counter) enabled by defining MUX_TREE_SCAN_EN.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    mux_tree_pipe_if.slave   bus
);
    localparam int unsigned LEVELS = $clog2(NUM_CH);
    localparam int unsigned TREE_W = (2 * NUM_CH - 1) * DATA_W;

    if ((NUM_CH < 2) || ((NUM_CH & (NUM_CH - 1)) != 0)) begin : g_bad_num_ch
        $error("mux_tree_pipe: NUM_CH must be a power of two and at least 2");
    end

    // Flattened tree: input items first, then each level's outputs, last item is the result
    logic [TREE_W-1:0] w_tree;
    logic [LEVELS:0]   w_v;
    logic [LEVELS-1:0] w_sel [LEVELS+1];
    logic [LEVELS-1:0] w_ld_dn;
    logic [LEVELS-1:0] w_in_sel;

`ifdef MUX_TREE_SCAN_EN
    logic [LEVELS-1:0] r_scan_cnt;
    logic              w_accept;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_in_sel = (bus.in_mode == MODE_EXT) ? bus.in_sel : r_scan_cnt;

    // Scan counter advances only on accepted scan-mode beats; wraps naturally at NUM_CH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
        end else if (w_accept && (bus.in_mode == MODE_SCAN)) begin
            r_scan_cnt <= r_scan_cnt + LEVELS'(1);
        end
    end
`else
    logic w_mode_unused;

    assign w_mode_unused = bus.in_mode;
    assign w_in_sel      = bus.in_sel;
`endif

    assign w_tree[NUM_CH*DATA_W-1:0] = bus.in_data;
    assign w_v[0]                    = bus.in_valid;
    assign w_sel[0]                  = w_in_sel;

    // Input side loads when out_ready or any stage holds a bubble
    assign bus.in_ready = bus.out_ready || !(&w_v[LEVELS:1]);

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        // Downstream load for stage k, expanded to avoid a combinational chain through stages
        if (k == LEVELS - 1) begin : g_last
            assign w_ld_dn[k] = bus.out_ready;
        end else begin : g_mid
            assign w_ld_dn[k] = bus.out_ready || !(&w_v[LEVELS:k+2]);
        end

        mux_tree_stage #(
            .LEVEL  (k),
            .NUM_CH (NUM_CH),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_v[k]),
            .i_data  (w_tree[tree_offset(NUM_CH, k)*DATA_W +: (NUM_CH>>k)*DATA_W]),
            .i_sel   (w_sel[k]),
            .i_ld_dn (w_ld_dn[k]),
            .o_valid (w_v[k+1]),
            .o_data  (w_tree[tree_offset(NUM_CH, k+1)*DATA_W +: (NUM_CH>>(k+1))*DATA_W]),
            .o_sel   (w_sel[k+1])
        );
    end

    assign bus.out_valid = w_v[LEVELS];
    assign bus.out_data  = w_tree[TREE_W-1 -: DATA_W];
    assign bus.out_ch    = w_sel[LEVELS];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe (NUM_CH=8, DATA_W=8) with a scoreboard queue.
module tb_mux_tree_pipe;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned DATA_W = 8;
    localparam logic [63:0] SWEEP  = 64'hA7A6_A5A4_A3A2_A1A0;
    localparam logic [63:0] PAT_A  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PAT_B  = 64'hFF00_FF00_FF00_FF00;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] ch;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  sel;
        logic        mode;
        logic [7:0]  exp_data;
        logic [2:0]  exp_ch;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_tree_pipe_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus_if ();

    mux_tree_pipe #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pops  = 0;
    int   neg_cnt = 0;
    exp_t sb_q[$];
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) neg_cnt++;

    // Output monitor: every offered beat must match the scoreboard head; pop on transfer
    always @(negedge clk) begin
        #2;
        if (rst === 1'b0 && bus_if.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: actual data %0h ch %0h required no beat",
                         bus_if.out_data, bus_if.out_ch);
            end else begin
                check("out_data", 32'(bus_if.out_data), 32'(sb_q[0].data));
                check("out_ch",   32'(bus_if.out_ch),   32'(sb_q[0].ch));
                if (bus_if.out_ready === 1'b1) begin
                    void'(sb_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [2:0] s, input logic m,
                        input exp_t e, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        @(negedge clk);
        bus_if.in_data  = d;
        bus_if.in_sel   = s;
        bus_if.in_mode  = m;
        bus_if.in_valid = 1'b1;
        for (int w = 0; w < 100 && !ok; w++) begin
            #1;
            if (bus_if.in_ready === 1'b1) begin
                sb_q.push_back(e);
                acc = neg_cnt;
                ok  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_vec(input vec_t v, output int acc);
        send(v.data, v.sel, v.mode, exp_t'{v.exp_data, v.exp_ch}, acc);
    endtask

    task automatic idle();
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        idle();
        for (int i = 0; i < 200 && !done; i++) begin
            #3;
            if (sb_q.size() == 0 && bus_if.out_valid === 1'b0) done = 1'b1;
            else @(negedge clk);
        end
        check({name, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic latency_beat(input vec_t v, input string name);
        int acc;
        int lat;
        bit seen;
        lat  = -1;
        seen = 1'b0;
        send_vec(v, acc);
        idle();
        for (int i = 0; i < 10 && !seen; i++) begin
            #3;
            if (bus_if.out_valid === 1'b1) begin
                lat  = neg_cnt - acc;
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check(name, 32'(lat), 32'd3);
        wait_drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc0;
        int acc2;
        int base;
        logic [2:0] scan_cnt;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{SWEEP, 3'(i), 1'b0, 8'hA0 + 8'(i), 3'(i)};
        end
        tbl[8]  = '{PAT_A, 3'd0, 1'b0, 8'hEF, 3'd0};
        tbl[9]  = '{PAT_A, 3'd7, 1'b0, 8'h01, 3'd7};
        tbl[10] = '{PAT_A, 3'd3, 1'b0, 8'h89, 3'd3};
        tbl[11] = '{PAT_A, 3'd5, 1'b0, 8'h45, 3'd5};
        tbl[12] = '{PAT_B, 3'd1, 1'b0, 8'hFF, 3'd1};
        tbl[13] = '{PAT_B, 3'd6, 1'b0, 8'h00, 3'd6};

        // Reset held two cycles with in_valid high and out_ready low
        rst              = 1'b1;
        bus_if.in_data   = SWEEP;
        bus_if.in_sel    = 3'd0;
        bus_if.in_mode   = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst             = 1'b0;
        bus_if.in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_data",  32'(bus_if.out_data),  32'd0);
        check("rst_out_ch",    32'(bus_if.out_ch),    32'd0);
        check("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        bus_if.out_ready = 1'b1;

        // First-beat latency from an empty pipe
        latency_beat(tbl[2], "latency");

        // Back-to-back sweep: 8 outputs must all leave by accept+10 (no gaps)
        base = n_pops;
        send_vec(tbl[0], acc0);
        for (int i = 1; i < 8; i++) send_vec(tbl[i], acc);
        idle();
        while (neg_cnt < acc0 + 10) @(negedge clk);
        #3;
        check("sweep_no_gap", 32'(n_pops - base), 32'd8);
        wait_drain("sweep");

        // Table of mixed data patterns
        for (int i = 8; i < 14; i++) send_vec(tbl[i], acc);
        wait_drain("pattern");

        // Backpressure: out_ready low for 5 cycles mid-stream
        base = n_pops;
        fork
            begin
                for (int i = 0; i < 8; i++) send_vec(tbl[7-i], acc);
            end
            begin
                repeat (3) @(negedge clk);
                bus_if.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                #1;
                check("bp_in_ready",  32'(bus_if.in_ready),  32'd0);
                check("bp_out_valid", 32'(bus_if.out_valid), 32'd1);
                @(negedge clk);
                bus_if.out_ready = 1'b1;
            end
        join
        wait_drain("bp");
        check("bp_count", 32'(n_pops - base), 32'd8);

        // Bubbles compress while output is stalled
        bus_if.out_ready = 1'b0;
        send_vec(tbl[1], acc0);
        idle();
        send_vec(tbl[2], acc);
        idle();
        send_vec(tbl[3], acc2);
        idle();
        #1;
        check("bubble_accept_gap", 32'(acc2 - acc0), 32'd4);
        check("bubble_in_ready",   32'(bus_if.in_ready),  32'd0);
        check("bubble_out_valid",  32'(bus_if.out_valid), 32'd1);
        bus_if.out_ready = 1'b1;
        wait_drain("bubble");

        // Reset with three beats in flight
        for (int i = 4; i < 7; i++) send_vec(tbl[i], acc);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_mid_in_ready",  32'(bus_if.in_ready),  32'd1);
        latency_beat(tbl[11], "rst_mid_latency");

`ifdef MUX_TREE_SCAN_EN
        // Scan mode with external-select beats interleaved
        scan_cnt = 3'd0;
        for (int i = 0; i < 10; i++) begin
            send(SWEEP, 3'd5, 1'b1, exp_t'{8'hA0 + 8'(scan_cnt), scan_cnt}, acc);
            scan_cnt = scan_cnt + 3'd1;
            if (i == 3 || i == 8) begin
                send(SWEEP, 3'(i - 1), 1'b0, exp_t'{8'hA0 + 8'(i - 1), 3'(i - 1)}, acc);
            end
        end
        wait_drain("scan");
`else
        // Without scan support in_mode is ignored
        scan_cnt = 3'd5;
        send(SWEEP, scan_cnt, 1'b1, exp_t'{8'hA0 + 8'(scan_cnt), scan_cnt}, acc);
        send(SWEEP, 3'd2, 1'b1, exp_t'{8'hA2, 3'd2}, acc);
        wait_drain("mode_ignored");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
